// File: rtl/des_key_sched_dec_if.sv
// Key-in / subkey-out handshake bundle for the DES decryption key schedule.
// weak_key exists only when DES_KS_WEAKKEY_EN is defined.
interface des_key_sched_dec_if;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key;
   logic        sk_valid;
   logic        sk_ready;
   logic [47:0] sk;
   logic [3:0]  sk_round;
   logic        sk_last;
`ifdef DES_KS_WEAKKEY_EN
   logic        weak_key;
`endif

   // Both channels use plain valid/ready: a transfer happens on a rising edge
   // where valid and ready are both high; a stalled producer holds its data stable.
   modport master (
`ifdef DES_KS_WEAKKEY_EN
      input  weak_key,
`endif
      output key_valid, input key_ready, output key,
      input  sk_valid, output sk_ready, input sk, input sk_round, input sk_last
   );

   modport slave (
`ifdef DES_KS_WEAKKEY_EN
      output weak_key,
`endif
      input  key_valid, output key_ready, input key,
      output sk_valid, input sk_ready, output sk, output sk_round, output sk_last
   );
endinterface

// File: rtl/des_key_sched_dec.sv
// Sequential DES decryption key schedule: emits K16..K1 by right-rotating C/D.
// Optional weak-key flag is enabled with the DES_KS_WEAKKEY_EN macro.
module des_key_sched_dec (
   input  logic                  clk,
   input  logic                  rst_n,
   des_key_sched_dec_if.slave    ks,
   output logic                  dbg_state
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

   // Entries are FIPS 46-3 bit numbers, 1 = MSB of the input vector.
   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
      return r;
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] h, input logic by_one);
      return by_one ? {h[0], h[27:1]} : {h[1:0], h[27:2]};
   endfunction

   state_e      state_q, state_d;
   logic [55:0] cd_q, cd_d;
   logic [3:0]  rnd_q, rnd_d;
   logic        weak_q, weak_d;
   logic [55:0] pc1_key;
   logic        shift_one;

   assign pc1_key = pc1(ks.key);
   // Undoing encryption round rnd+1, whose left shift was 1 for rounds 1, 2, 9, 16.
   assign shift_one = (rnd_q == 4'd15) || (rnd_q == 4'd8) || (rnd_q == 4'd1);

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      rnd_d   = rnd_q;
      weak_d  = weak_q;
      case (state_q)
         S_IDLE: begin
            if (ks.key_valid) begin
               cd_d    = pc1_key;
               rnd_d   = 4'd15;
               state_d = S_RUN;
               weak_d  = ((pc1_key[55:28] == '0) || (pc1_key[55:28] == '1)) &&
                         ((pc1_key[27:0]  == '0) || (pc1_key[27:0]  == '1));
            end
         end
         S_RUN: begin
            if (ks.sk_ready) begin
               if (rnd_q == 4'd0) begin
                  state_d = S_IDLE;
               end else begin
                  cd_d  = {rotr(cd_q[55:28], shift_one), rotr(cd_q[27:0], shift_one)};
                  rnd_d = rnd_q - 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cd_q    <= '0;
         rnd_q   <= '0;
         weak_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         rnd_q   <= rnd_d;
         weak_q  <= weak_d;
      end
   end

   assign ks.key_ready = (state_q == S_IDLE);
   assign ks.sk_valid  = (state_q == S_RUN);
   assign ks.sk        = pc2(cd_q);
   assign ks.sk_round  = rnd_q;
   assign ks.sk_last   = (rnd_q == 4'd0);
   assign dbg_state    = (state_q == S_RUN);

`ifdef DES_KS_WEAKKEY_EN
   assign ks.weak_key = weak_q;
`else
   logic unused_weak;
   assign unused_weak = weak_q;
`endif

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Directed bench for des_key_sched_dec using the classic 133457799BBCDFF1 schedule.
// Weak-key checks are compiled in only with DES_KS_WEAKKEY_EN.
module tb_des_key_sched_dec;

   logic clk;
   logic rst_n;
   logic dbg_state;
   int   n_cmp;
   int   n_err;
   logic [47:0] kx [16];

   des_key_sched_dec_if bus();

   des_key_sched_dec dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ks        (bus),
      .dbg_state (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_key(input string tag, input logic [63:0] k);
      chk({tag, " key_ready before send"}, 64'(bus.key_ready), 64'd1);
      bus.key       = k;
      bus.key_valid = 1'b1;
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
   endtask

   // mode 0: reference table, 1: all zeros, 2: all ones
   task automatic drain(input string tag, input int mode, input bit stall);
      logic [47:0] exp;
      int guard;
      for (int r = 15; r >= 0; r--) begin
         exp = (mode == 1) ? 48'h0 : (mode == 2) ? 48'hFFFF_FFFF_FFFF : kx[r];
         if (stall && r == 7) begin
            bus.sk_ready = 1'b0;
            repeat (5) begin
               @(posedge clk); #1;
               chk($sformatf("%s stall sk", tag), 64'(bus.sk), 64'(exp));
               chk($sformatf("%s stall round", tag), 64'(bus.sk_round), 64'd7);
            end
         end
         bus.sk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         chk($sformatf("%s valid r%0d", tag, r), 64'(bus.sk_valid), 64'd1);
         chk($sformatf("%s key_ready r%0d", tag, r), 64'(bus.key_ready), 64'd0);
         chk($sformatf("%s sk r%0d", tag, r), 64'(bus.sk), 64'(exp));
         chk($sformatf("%s round r%0d", tag, r), 64'(bus.sk_round), 64'(r));
         chk($sformatf("%s last r%0d", tag, r), 64'(bus.sk_last), 64'(r == 0));
         guard = 0;
         while (!bus.sk_ready) begin
            @(posedge clk); #1;
            chk($sformatf("%s hold sk r%0d", tag, r), 64'(bus.sk), 64'(exp));
            chk($sformatf("%s hold round r%0d", tag, r), 64'(bus.sk_round), 64'(r));
            guard++;
            bus.sk_ready = (guard > 8) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      bus.sk_ready = 1'b1;
      chk({tag, " key_ready after K1"}, 64'(bus.key_ready), 64'd1);
      chk({tag, " sk_valid after K1"}, 64'(bus.sk_valid), 64'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      kx = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
             48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
             48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
             48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
      rst_n         = 1'b0;
      bus.key_valid = 1'b0;
      bus.key       = '0;
      bus.sk_ready  = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst key_ready", 64'(bus.key_ready), 64'd1);
      chk("rst sk_valid", 64'(bus.sk_valid), 64'd0);
      chk("rst sk", 64'(bus.sk), 64'd0);
      chk("rst sk_round", 64'(bus.sk_round), 64'd0);
      chk("rst sk_last", 64'(bus.sk_last), 64'd1);
      chk("rst dbg_state", 64'(dbg_state), 64'd0);
`ifdef DES_KS_WEAKKEY_EN
      chk("rst weak_key", 64'(bus.weak_key), 64'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle ignores sk_ready", 64'(bus.sk_valid), 64'd0);

      // Reference key, sk_ready held high
      send_key("ref", 64'h133457799BBCDFF1);
      chk("ref dbg_state", 64'(dbg_state), 64'd1);
`ifdef DES_KS_WEAKKEY_EN
      chk("ref weak_key", 64'(bus.weak_key), 64'd0);
`endif
      drain("ref", 0, 1'b0);

      // Same key with random backpressure and a 5-cycle stall at round 7
      send_key("stall", 64'h133457799BBCDFF1);
      drain("stall", 0, 1'b1);

      // Weak keys
      send_key("weak0", 64'h0101010101010101);
`ifdef DES_KS_WEAKKEY_EN
      chk("weak0 weak_key", 64'(bus.weak_key), 64'd1);
`endif
      drain("weak0", 1, 1'b0);
      send_key("weak1", 64'hFEFEFEFEFEFEFEFE);
`ifdef DES_KS_WEAKKEY_EN
      chk("weak1 weak_key", 64'(bus.weak_key), 64'd1);
`endif
      drain("weak1", 2, 1'b0);

      // key_valid held through RUN with another key pending
      send_key("held", 64'h133457799BBCDFF1);
      bus.key       = 64'hFEFEFEFEFEFEFEFE;
      bus.key_valid = 1'b1;
      drain("held", 0, 1'b0);
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      drain("held next", 2, 1'b0);

      // Asynchronous reset in the middle of a sequence
      send_key("mid", 64'h133457799BBCDFF1);
      repeat (6) @(posedge clk);
      #1;
      chk("mid round before reset", 64'(bus.sk_round), 64'd9);
      chk("mid sk before reset", 64'(bus.sk), 64'(kx[9]));
      rst_n = 1'b0;
      #1;
      chk("mid reset sk_valid", 64'(bus.sk_valid), 64'd0);
      chk("mid reset key_ready", 64'(bus.key_ready), 64'd1);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid after reset sk_valid", 64'(bus.sk_valid), 64'd0);
      send_key("restart", 64'h133457799BBCDFF1);
      drain("restart", 0, 1'b0);

      // Parity bits toggled in every byte
      send_key("parity", 64'h123556789ABDDEF0);
      drain("parity", 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
